// File: rtl/alu_seq_pkg.sv
//------------------------------------------------------------------------------
// alu_seq_pkg: ALU command codes shared with controllers, plus ALU state codes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  localparam int AC_N = 3;
  localparam logic [AC_N-1:0] AC_AD = 3'd0;
  localparam logic [AC_N-1:0] AC_SB = 3'd1;
  localparam logic [AC_N-1:0] AC_MU = 3'd2;
  localparam logic [AC_N-1:0] AC_DI = 3'd3;

  localparam int AS_N = 2;
  typedef enum logic [AS_N-1:0] {
    AS_IDLE = 2'd0,
    AS_MUL  = 2'd1,
    AS_DIV  = 2'd2,
    AS_FIX  = 2'd3
  } as_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_divstep.sv
//------------------------------------------------------------------------------
// alu_divstep: one combinational restoring-division step on unsigned magnitudes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_divstep #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem_in,
  input  logic [N-1:0] divisor,
  input  logic         bit_in,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0]   shifted;
  logic [N-1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    // When the subtraction is taken the true difference is below divisor, so N bits suffice.
    diff    = shifted[N-1:0] - divisor;
    rem_out = q_bit ? diff : shifted[N-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// alu_seq: sequential signed ALU (1-cycle add/sub, bit-serial mul/div), start/busy/done.
// Optional macro ALU_OVF_EN adds the al_ovf port and overflow detection.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            al_start,
  input  logic [N-1:0]    al_A,
  input  logic [N-1:0]    al_B,
  input  logic [AC_N-1:0] al_cmd,
  output logic            al_busy,
  output logic            al_done,
  output logic [N-1:0]    al_C,
  output logic            al_dz
`ifdef ALU_OVF_EN
  ,
  output logic            al_ovf
`endif
);

  as_state_e      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]   opa, opb;
  logic [2*N-1:0] prod, prod_step;
  logic           neg;
  logic [N-1:0]   result;
  logic           done_r, dz_r;

  logic [N-1:0]   abs_a, abs_b, sum, dif, res_fix;
  logic [N:0]     mul_sum;
  logic [N-1:0]   div_rem;
  logic           div_q;

  alu_divstep #(.N(N)) u_divstep (
    .rem_in  (prod[2*N-1:N]),
    .divisor (opb),
    .bit_in  (prod[N-1]),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  // prod holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    abs_a     = al_A[N-1] ? -al_A : al_A;
    abs_b     = al_B[N-1] ? -al_B : al_B;
    sum       = al_A + al_B;
    dif       = al_A - al_B;
    mul_sum   = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, opa} : {(N+1){1'b0}});
    prod_step = (state == AS_DIV) ? {div_rem, prod[N-2:0], div_q}
                                  : {mul_sum, prod[N-1:1]};
    res_fix   = neg ? -prod_step[N-1:0] : prod_step[N-1:0];
  end

`ifdef ALU_OVF_EN
  logic ovf_r, ovf_fast, ovf_fix;

  always_comb begin
    if (al_cmd == AC_SB)
      ovf_fast = (al_A[N-1] != al_B[N-1]) && (dif[N-1] != al_A[N-1]);
    else
      ovf_fast = (al_A[N-1] == al_B[N-1]) && (sum[N-1] != al_A[N-1]);
    // A negative product may reach exactly -2**(N-1); a positive one may not.
    if (state == AS_DIV)
      ovf_fix = ~neg & prod_step[N-1];
    else
      ovf_fix = (prod_step[2*N-1:N-1] != '0) &&
                !(neg && (prod_step[2*N-1:N-1] == (N+1)'(1)) && (prod_step[N-2:0] == '0));
  end

  assign al_ovf = ovf_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= AS_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      AS_IDLE: begin
        if (al_start) begin
          if (al_cmd == AC_MU)
            state_next = AS_MUL;
          else if ((al_cmd == AC_DI) && (al_B != '0))
            state_next = AS_DIV;
        end
      end
      AS_MUL, AS_DIV: begin
        if (cnt == '0) state_next = AS_FIX;
      end
      default: state_next = AS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      prod   <= '0;
      neg    <= 1'b0;
      result <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        AS_IDLE: begin
          if (al_start) begin
            opa <= abs_a;
            opb <= abs_b;
            neg <= al_A[N-1] ^ al_B[N-1];
            cnt <= CNT_W'(N-1);
            case (al_cmd)
              AC_MU: prod <= {{N{1'b0}}, abs_b};
              AC_DI: begin
                if (al_B != '0) begin
                  prod <= {{N{1'b0}}, abs_a};
                end else begin
                  result <= '0;
                  dz_r   <= 1'b1;
                  done_r <= 1'b1;
`ifdef ALU_OVF_EN
                  ovf_r  <= 1'b0;
`endif
                end
              end
              default: begin
                result <= (al_cmd == AC_SB) ? dif : sum;
                dz_r   <= 1'b0;
                done_r <= 1'b1;
`ifdef ALU_OVF_EN
                ovf_r  <= ovf_fast;
`endif
              end
            endcase
          end
        end
        AS_MUL, AS_DIV: begin
          prod <= prod_step;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            result <= res_fix;
            dz_r   <= 1'b0;
            done_r <= 1'b1;
`ifdef ALU_OVF_EN
            ovf_r  <= ovf_fix;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign al_busy = (state != AS_IDLE);
  assign al_done = done_r;
  assign al_C    = result;
  assign al_dz   = dz_r;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//------------------------------------------------------------------------------
// tb_alu_seq: directed and random checks of alu_seq against a signed-arithmetic model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int N = 32;
  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  logic            clk;
  logic            rst;
  logic            al_start;
  logic [N-1:0]    al_A, al_B;
  logic [AC_N-1:0] al_cmd;
  logic            al_busy, al_done, al_dz;
  logic [N-1:0]    al_C;
`ifdef ALU_OVF_EN
  logic            al_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  alu_seq #(.N(N), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .al_start (al_start),
    .al_A     (al_A),
    .al_B     (al_B),
    .al_cmd   (al_cmd),
    .al_busy  (al_busy),
    .al_done  (al_done),
    .al_C     (al_C),
    .al_dz    (al_dz)
`ifdef ALU_OVF_EN
    ,
    .al_ovf   (al_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit values, then wrap to N bits.
  function automatic void model(input logic [AC_N-1:0] cmd, input logic [N-1:0] a,
                                input logic [N-1:0] b, output logic [N-1:0] r,
                                output logic dz, output logic ov, output int lat);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0; ov = 1'b0; lat = 1; p = 0;
    if (cmd == AC_MU) begin
      p = sa * sb; lat = N + 1;
    end else if (cmd == AC_DI) begin
      if (sb == 0) begin
        dz = 1'b1;
      end else begin
        p = sa / sb; lat = N + 1;
      end
    end else if (cmd == AC_SB) begin
      p = sa - sb;
    end else begin
      p = sa + sb;
    end
    r  = p[N-1:0];
    ov = (p > MAXP) || (p < MINN);
  endfunction

  task automatic run_op(input logic [AC_N-1:0] cmd, input logic [N-1:0] a,
                        input logic [N-1:0] b, input string tag);
    logic [N-1:0] er;
    logic edz, eov;
    int elat, cyc;
    bit seen;
    model(cmd, a, b, er, edz, eov, elat);
    @(negedge clk);
    al_start = 1'b1; al_cmd = cmd; al_A = a; al_B = b;
    @(posedge clk); #1;
    al_start = 1'b0;
    cyc = 1; seen = 0;
    chk({tag, " busy_first"}, 64'(al_busy), 64'(elat > 1));
    while (cyc <= 40) begin
      if (al_done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, seen ? 64'(cyc) : '1, 64'(elat));
    if (seen) begin
      chk({tag, " C"}, 64'(al_C), 64'(er));
      chk({tag, " dz"}, 64'(al_dz), 64'(edz));
      chk({tag, " busy_done"}, 64'(al_busy), 64'(elat > 1));
`ifdef ALU_OVF_EN
      chk({tag, " ovf"}, 64'(al_ovf), 64'(eov));
`endif
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, 64'(al_done), 64'(0));
      chk({tag, " C_held"}, 64'(al_C), 64'(er));
      chk({tag, " busy_after"}, 64'(al_busy), 64'(0));
    end
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = N'($urandom_range(1, 20));
      4: v = -N'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int cyc;
    bit seen;
    logic [AC_N-1:0] rc;

    rst = 1'b1; al_start = 1'b0; al_cmd = AC_AD; al_A = '0; al_B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(al_busy), 64'(0));
    chk("reset done", 64'(al_done), 64'(0));
    chk("reset C", 64'(al_C), 64'(0));
    chk("reset dz", 64'(al_dz), 64'(0));
    rst = 1'b0;

    run_op(AC_AD, 32'd7, 32'd5, "ad_7_5");
    run_op(AC_SB, 32'd0, 32'd3, "sb_0_3");
    run_op(AC_MU, -32'd6, 32'd7, "mu_m6_7");
    run_op(AC_MU, 32'h10000, 32'h10000, "mu_wrap");
    run_op(AC_MU, 32'h8000_0000, 32'hFFFF_FFFF, "mu_min_m1");
    run_op(AC_DI, -32'd7, 32'd2, "di_m7_2");
    run_op(AC_DI, 32'd7, -32'd2, "di_7_m2");
    run_op(AC_DI, 32'd5, 32'd0, "di_by0");
    run_op(AC_DI, 32'h8000_0000, 32'hFFFF_FFFF, "di_min_m1");
    run_op(3'd5, 32'd3, 32'd4, "unknown_cmd");
    run_op(AC_AD, 32'h7FFF_FFFF, 32'd1, "ad_wrap");

    // Start during a divide is ignored.
    @(negedge clk);
    al_start = 1'b1; al_cmd = AC_DI; al_A = 32'd100; al_B = 32'd10;
    @(posedge clk); #1;
    al_start = 1'b0; cyc = 1; seen = 0;
    while (cyc <= 40 && !seen) begin
      if (al_done) begin
        seen = 1;
      end else begin
        if (cyc == 4) begin
          al_start = 1'b1; al_cmd = AC_AD; al_A = 32'd1; al_B = 32'd1;
        end else begin
          al_start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    al_start = 1'b0;
    chk("ignore latency", seen ? 64'(cyc) : '1, 64'(N + 1));
    chk("ignore C", 64'(al_C), 64'(10));
    @(posedge clk); #1;
    chk("ignore no_second_done", 64'(al_done), 64'(0));
    chk("ignore idle", 64'(al_busy), 64'(0));

    // Start accepted in the same cycle as a done pulse.
    @(negedge clk);
    al_start = 1'b1; al_cmd = AC_AD; al_A = 32'd7; al_B = 32'd5;
    @(posedge clk); #1;
    chk("b2b first_done", 64'(al_done), 64'(1));
    chk("b2b first_C", 64'(al_C), 64'(12));
    al_cmd = AC_SB; al_A = 32'd10; al_B = 32'd20;
    @(posedge clk); #1;
    al_start = 1'b0;
    chk("b2b second_done", 64'(al_done), 64'(1));
    chk("b2b second_C", 64'(al_C), 64'(32'hFFFF_FFF6));
    @(posedge clk); #1;
    chk("b2b done_drop", 64'(al_done), 64'(0));

    // Reset in the middle of a multiply.
    @(negedge clk);
    al_start = 1'b1; al_cmd = AC_MU; al_A = -32'd6; al_B = 32'd7;
    @(posedge clk); #1;
    al_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst busy_before", 64'(al_busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy", 64'(al_busy), 64'(0));
    chk("midrst C", 64'(al_C), 64'(0));
    chk("midrst done", 64'(al_done), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("midrst stays_idle", 64'(al_done), 64'(0));
    run_op(AC_AD, 32'd2, 32'd2, "after_rst_ad");

    for (int i = 0; i < 40; i++) begin
      rc = AC_N'($urandom_range(0, 5));
      run_op(rc, pick(), pick(), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
